// File: rtl/memory_stage.sv
// Pipeline memory stage: drives a req/ack data-memory bus and loads the MEM/WB register.
// Define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of truncating them.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteEnM,
    input  logic        MemtoRegM,
    input  logic        JALM,
    input  logic        MemReadEnM,
    input  logic        MemWriteEnM,
    input  logic [1:0]  MemSizeM,
    input  logic [1:0]  LoadSizeM,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ReadData2M,
    input  logic [31:0] PcPlus4M,
    output logic        DMemReqO,
    output logic        DMemWeO,
    output logic [31:0] DMemAddrO,
    output logic [31:0] DMemWdataO,
    output logic [3:0]  DMemBeO,
    input  logic        DMemAckI,
    input  logic [31:0] DMemRdataI,
    output logic        StallM,
    output logic        RegWriteEnW,
    output logic        MemtoRegW,
    output logic        JALW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [1:0]  off;
    logic        memOp;
    logic        misaligned;
    logic        busOp;
    logic [3:0]  beCalc;
    logic [31:0] wdataCalc;
    logic [31:0] loadData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        unusedLoadSize;

    // Bit 1 of the load-size field is reserved.
    assign unusedLoadSize = LoadSizeM[1];

    assign off   = ALUResultM[1:0];
    assign memOp = MemReadEnM | MemWriteEnM;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = memOp && (((MemSizeM == 2'b01) && off[0]) || (MemSizeM[1] && (off != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign busOp  = memOp && !misaligned;
    assign StallM = busOp && !((state == ACCESS) && DMemAckI);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        beCalc    = 4'b1111;
        wdataCalc = ReadData2M;
        case (MemSizeM)
            2'b00: begin
                beCalc    = 4'b0001 << off;
                wdataCalc = {4{ReadData2M[7:0]}};
            end
            2'b01: begin
                beCalc    = 4'b0011 << {off[1], 1'b0};
                wdataCalc = {2{ReadData2M[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection relies on the M inputs being held stable until ack.
    always_comb begin
        byteSel  = DMemRdataI[{off, 3'b000} +: 8];
        halfSel  = off[1] ? DMemRdataI[31:16] : DMemRdataI[15:0];
        loadData = DMemRdataI;
        case (MemSizeM)
            2'b00:   loadData = LoadSizeM[0] ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
            2'b01:   loadData = LoadSizeM[0] ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            DMemReqO    <= 1'b0;
            DMemWeO     <= 1'b0;
            DMemAddrO   <= 32'b0;
            DMemWdataO  <= 32'b0;
            DMemBeO     <= 4'b0;
            RegWriteEnW <= 1'b0;
            MemtoRegW   <= 1'b0;
            JALW        <= 1'b0;
            RdW         <= 5'b0;
            ALUResultW  <= 32'b0;
            ReadDataW   <= 32'b0;
            PCPlus4W    <= 32'b0;
            MisalignW   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (busOp) begin
                        state      <= ACCESS;
                        DMemReqO   <= 1'b1;
                        DMemWeO    <= MemWriteEnM;
                        DMemAddrO  <= {ALUResultM[31:2], 2'b00};
                        DMemBeO    <= MemWriteEnM ? beCalc : 4'b0000;
                        DMemWdataO <= wdataCalc;
                    end
                end
                ACCESS: begin
                    if (DMemAckI) begin
                        state    <= IDLE;
                        DMemReqO <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (StallM) begin
                RegWriteEnW <= 1'b0;
                MemtoRegW   <= 1'b0;
                JALW        <= 1'b0;
                RdW         <= 5'b0;
                ALUResultW  <= 32'b0;
                ReadDataW   <= 32'b0;
                PCPlus4W    <= 32'b0;
                MisalignW   <= 1'b0;
            end else begin
                RegWriteEnW <= RegWriteEnM && !misaligned;
                MemtoRegW   <= MemtoRegM;
                JALW        <= JALM;
                RdW         <= RdM;
                ALUResultW  <= ALUResultM;
                ReadDataW   <= (busOp && !MemWriteEnM) ? loadData : 32'b0;
                PCPlus4W    <= PcPlus4M;
                MisalignW   <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized bench for memory_stage with a behavioural memory/writeback model.
// Define MEM_MISALIGN_CHECK_EN for both bench and RTL to exercise the misalignment trap.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
    logic [1:0]  MemSizeM, LoadSizeM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, ReadData2M, PcPlus4M;
    logic        DMemReqO, DMemWeO;
    logic [31:0] DMemAddrO, DMemWdataO;
    logic [3:0]  DMemBeO;
    logic        DMemAckI;
    logic [31:0] DMemRdataI;
    logic        StallM;
    logic        RegWriteEnW, MemtoRegW, JALW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic        MisalignW;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    memory_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
        .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
        .MemSizeM(MemSizeM), .LoadSizeM(LoadSizeM), .RdM(RdM),
        .ALUResultM(ALUResultM), .ReadData2M(ReadData2M), .PcPlus4M(PcPlus4M),
        .DMemReqO(DMemReqO), .DMemWeO(DMemWeO), .DMemAddrO(DMemAddrO),
        .DMemWdataO(DMemWdataO), .DMemBeO(DMemBeO),
        .DMemAckI(DMemAckI), .DMemRdataI(DMemRdataI),
        .StallM(StallM),
        .RegWriteEnW(RegWriteEnW), .MemtoRegW(MemtoRegW), .JALW(JALW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the access rules.
    function automatic logic [3:0] expBe(input logic wr, input logic [1:0] size, input logic [1:0] off);
        if (!wr) return 4'h0;
        if (size == 2'd0) return 4'(1 << off);
        if (size == 2'd1) return 4'(3 << (2 * (off / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] st);
        if (size == 2'd0) return {24'b0, st[7:0]} * 32'h0101_0101;
        if (size == 2'd1) return {16'b0, st[15:0]} * 32'h0001_0001;
        return st;
    endfunction

    function automatic logic [31:0] expLoad(input logic [1:0] size, input logic [1:0] ls,
                                            input logic [1:0] off, input logic [31:0] w);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!ls[0] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!ls[0] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic badAlign(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd1 && off % 2 == 1) || (size >= 2'd2 && off != 2'd0);
    endfunction

    task automatic checkWb(input logic regW, m2r, jal, input logic [4:0] rd,
                           input logic [31:0] alu, rdata, pc, input logic mis);
        check("RegWriteEnW", RegWriteEnW, regW);
        check("MemtoRegW", MemtoRegW, m2r);
        check("JALW", JALW, jal);
        check("RdW", RdW, rd);
        check("ALUResultW", ALUResultW, alu);
        check("ReadDataW", ReadDataW, rdata);
        check("PCPlus4W", PCPlus4W, pc);
        check("MisalignW", MisalignW, mis);
    endtask

    task automatic checkBusIdle();
        check("DMemReqO_rst", DMemReqO, 0);
        check("DMemWeO_rst", DMemWeO, 0);
        check("DMemAddrO_rst", DMemAddrO, 0);
        check("DMemWdataO_rst", DMemWdataO, 0);
        check("DMemBeO_rst", DMemBeO, 0);
    endtask

    // Applies one instruction at the start of a cycle and plays the memory with ack after 'lat' req cycles.
    task automatic doOp(input logic rdEn, wrEn, regW, m2r, jal, input logic [1:0] size, ls,
                        input logic [4:0] rd, input logic [31:0] alu, st, pc,
                        input int lat, input logic [31:0] rdata, output int stalls);
        logic       memOp, mis;
        logic [1:0] off;
        MemReadEnM = rdEn;  MemWriteEnM = wrEn;  RegWriteEnM = regW;
        MemtoRegM  = m2r;   JALM = jal;          MemSizeM = size;
        LoadSizeM  = ls;    RdM = rd;            ALUResultM = alu;
        ReadData2M = st;    PcPlus4M = pc;       DMemAckI = 1'b0;
        DMemRdataI = rdata;
        memOp  = rdEn | wrEn;
        off    = alu[1:0];
        mis    = CheckEn && memOp && badAlign(size, off);
        stalls = 0;
        #2;
        if (mis) begin
            check("stall_misalign", StallM, 0);
            check("req_misalign", DMemReqO, 0);
            tick();
            check("req_after_misalign", DMemReqO, 0);
            check("RegWriteEnW_misalign", RegWriteEnW, 0);
            check("MisalignW_misalign", MisalignW, 1);
        end else if (!memOp) begin
            check("stall_nomem", StallM, 0);
            check("req_nomem", DMemReqO, 0);
            tick();
            checkWb(regW, m2r, jal, rd, alu, 32'b0, pc, 1'b0);
        end else begin
            check("stall_idle", StallM, 1);
            check("req_idle", DMemReqO, 0);
            stalls = 1;
            tick();
            check("bubble_regw", RegWriteEnW, 0);
            for (int k = 0; k <= lat; k++) begin
                DMemAckI = (k == lat);
                #2;
                check("DMemReqO", DMemReqO, 1);
                check("DMemWeO", DMemWeO, wrEn);
                check("DMemAddrO", DMemAddrO, {alu[31:2], 2'b00});
                check("DMemBeO", DMemBeO, expBe(wrEn, size, off));
                if (wrEn) check("DMemWdataO", DMemWdataO, expWdata(size, st));
                check("StallM_access", StallM, k != lat);
                if (StallM) stalls++;
                tick();
                if (k != lat) begin
                    check("bubble_regw", RegWriteEnW, 0);
                    check("bubble_m2r", MemtoRegW, 0);
                    check("bubble_jal", JALW, 0);
                end
            end
            DMemAckI = 1'b0;
            check("req_drop", DMemReqO, 0);
            checkWb(regW, m2r, jal, rd, alu, wrEn ? 32'b0 : expLoad(size, ls, off, rdata), pc, 1'b0);
        end
    endtask

    initial begin
        int stalls;
        logic [1:0] kind;
        rst = 1'b1;
        {RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM} = '0;
        MemSizeM = '0; LoadSizeM = '0; RdM = '0;
        ALUResultM = '0; ReadData2M = '0; PcPlus4M = '0;
        DMemAckI = 1'b0; DMemRdataI = '0;
        tick();
        tick();
        #2;
        checkBusIdle();
        checkWb(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0);
        check("StallM_rst", StallM, 0);
        rst = 1'b0;
        tick();

        // Word load with ack in the second request cycle: two stall cycles.
        doOp(1, 0, 1, 1, 0, 2'b10, 2'b00, 5'd7, 32'h0000_0100, 32'h0, 32'h0000_1004, 1, 32'hDEAD_BEEF, stalls);
        check("stall_cycles_word_load", stalls, 2);
        check("ReadDataW_deadbeef", ReadDataW, 32'hDEAD_BEEF);

        // Byte store 0xAB to 0x203.
        doOp(0, 1, 0, 0, 0, 2'b00, 2'b00, 5'd0, 32'h0000_0203, 32'h1234_56AB, 32'h0000_2000, 0, 32'h0, stalls);

        // Byte load from 0x201: signed then unsigned.
        doOp(1, 0, 1, 1, 0, 2'b00, 2'b00, 5'd3, 32'h0000_0201, 32'h0, 32'h0000_3000, 0, 32'h0000_8000, stalls);
        check("ReadDataW_sbyte", ReadDataW, 32'hFFFF_FF80);
        doOp(1, 0, 1, 1, 0, 2'b00, 2'b01, 5'd3, 32'h0000_0201, 32'h0, 32'h0000_3000, 0, 32'h0000_8000, stalls);
        check("ReadDataW_ubyte", ReadDataW, 32'h0000_0080);

        // Ack held off for five request cycles.
        doOp(1, 0, 1, 0, 0, 2'b01, 2'b00, 5'd9, 32'h0000_0406, 32'h0, 32'h0000_4000, 5, 32'h8001_1234, stalls);
        check("stall_cycles_slow_ack", stalls, 6);

        // Reset in the middle of an access with ack in the same cycle.
        MemReadEnM = 1'b1; MemWriteEnM = 1'b0; RegWriteEnM = 1'b1; MemtoRegM = 1'b1;
        JALM = 1'b1; MemSizeM = 2'b10; RdM = 5'd12; ALUResultM = 32'h0000_0500;
        PcPlus4M = 32'h0000_5004; DMemRdataI = 32'hCAFE_F00D; DMemAckI = 1'b0;
        tick();
        #2;
        check("req_before_rst", DMemReqO, 1);
        rst = 1'b1;
        DMemAckI = 1'b1;
        tick();
        checkBusIdle();
        checkWb(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0);
        rst = 1'b0;
        DMemAckI = 1'b0;
        doOp(0, 0, 1, 0, 1, 2'b00, 2'b00, 5'd1, 32'h1111_2222, 32'h0, 32'h0000_6004, 0, 32'h0, stalls);
        doOp(1, 0, 1, 1, 0, 2'b10, 2'b00, 5'd13, 32'h0000_0600, 32'h0, 32'h0000_6008, 0, 32'h0BAD_F00D, stalls);
        check("stall_cycles_after_rst", stalls, 1);

`ifdef MEM_MISALIGN_CHECK_EN
        doOp(1, 0, 1, 1, 0, 2'b10, 2'b00, 5'd4, 32'h0000_0102, 32'h0, 32'h0000_7004, 0, 32'h0, stalls);
        doOp(0, 0, 1, 0, 0, 2'b00, 2'b00, 5'd5, 32'h0000_0042, 32'h0, 32'h0000_7008, 0, 32'h0, stalls);
        check("MisalignW_one_cycle", MisalignW, 0);
`endif

        // Randomized mix of loads, stores and ALU ops.
        for (int i = 0; i < 60; i++) begin
            kind = 2'($urandom_range(0, 3));
            doOp(kind[0], kind[1], 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), $urandom, stalls);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
REQ-002 SHALL have these inputs from the EX/MEM register:
- RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  in  1 each  control.
- MemSizeM  in  2  access size: 00 byte, 01 half, 10/11 word.
- LoadSizeM  in  2  load extension: bit0 = 1 zero-extend, bit0 = 0 sign-extend; bit1 reserved and ignored.
- RdM  in  5  destination register.
- ALUResultM  in  32  effective address or ALU result.
- ReadData2M  in  32  store data.
- PcPlus4M  in  32  link value.
REQ-003 SHALL have these data-memory bus ports:
- DMemReqO  out  1  request.
- DMemWeO  out  1  write.
- DMemAddrO  out  32  word-aligned address.
- DMemWdataO  out  32  store data.
- DMemBeO  out  4  byte enables.
- DMemAckI  in  1  acknowledge.
- DMemRdataI  in  32  read word.
REQ-004 SHALL have StallM  out  1: upstream must hold all M inputs stable while it is high.
REQ-005 SHALL have these outputs to writeback:
- RegWriteEnW, MemtoRegW, JALW  out  1 each.
- RdW  out  5.
- ALUResultW, ReadDataW, PCPlus4W  out  32 each.
- MisalignW  out  1.

Function
REQ-006 SHALL implement a two-state FSM, IDLE and ACCESS.
REQ-007 A memory op is MemReadEnM|MemWriteEnM; if both are high, the op SHALL be a write.
REQ-008 In IDLE with a memory op present, the FSM SHALL go to ACCESS on the next edge.
REQ-009 On that IDLE->ACCESS edge, DMemReqO SHALL go high, with DMemAddrO, DMemWeO, DMemBeO and DMemWdataO registered from the M inputs.
REQ-010 In ACCESS, DMemReqO and all bus outputs SHALL hold stable until a cycle with DMemAckI=1. On that edge:
- the FSM returns to IDLE;
- DMemReqO drops;
- the WB register loads the instruction.
REQ-011 DMemAckI SHALL be ignored in IDLE.
REQ-012 StallM SHALL be combinational: high when a memory op is present and NOT (state==ACCESS and DMemAckI).
- Minimum memory-op residency is 2 cycles; a non-memory op takes 1 cycle.
REQ-013 While StallM=1, the WB register SHALL load a bubble: RegWriteEnW=0, MemtoRegW=0, JALW=0, MisalignW=0.
REQ-014 A non-memory op SHALL pass to the WB register on the next edge with ReadDataW=0.
REQ-015 DMemAddrO SHALL be {ALUResultM[31:2],2'b00}, with off=ALUResultM[1:0].
REQ-016 DMemBeO SHALL be: byte 0001<<off; half 0011<<(off[1]*2); word 1111. All zero for reads.
REQ-017 DMemWdataO SHALL be: byte {4{ReadData2M[7:0]}}; half {2{ReadData2M[15:0]}}; word ReadData2M.
REQ-018 On ack of a read, ReadDataW SHALL be the selected lane (byte at off, half at off[1]), extended to 32 bits per LoadSizeM[0]. Word loads are unmodified.
REQ-019 A write SHALL yield ReadDataW=0; other WB fields pass through unchanged.

Reset
REQ-020 On rst, the block SHALL force:
- FSM to IDLE;
- DMemReqO=0, DMemWeO=0, DMemBeO=0, DMemAddrO=0, DMemWdataO=0;
- all WB outputs to 0.
REQ-021 rst during ACCESS SHALL abandon the access: DMemReqO=0 after the reset edge, and an ack in that cycle is ignored.
REQ-022 rst SHALL take priority over ack and over new ops.

Configuration
REQ-023 With macro MEM_MISALIGN_CHECK_EN defined:
- A half op with off[0]=1, or a word op with off!=0, is misaligned.
- A misaligned op SHALL issue no bus request and SHALL NOT raise StallM.
- On the next edge it SHALL load the WB register with RegWriteEnW=0 and MisalignW=1 for one cycle.
REQ-024 Without MEM_MISALIGN_CHECK_EN:
- no alignment check is made;
- misaligned ops proceed per REQ-015..018 (address truncated);
- MisalignW is constant 0.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Word load, addr 0x100, ack one cycle after req, DMemRdataI=0xDEADBEEF -> StallM high 2 cycles; ReadDataW=0xDEADBEEF, RegWriteEnW=1, RdW as given.
- Byte store 0xAB to 0x203 -> DMemAddrO=0x200, DMemBeO=1000, DMemWdataO=0xABABABAB, DMemWeO=1.
- Signed byte load from 0x201, rdata 0x00008000 -> ReadDataW=0xFFFFFF80. Same access with LoadSizeM=01 -> 0x00000080.
- Ack held low 5 cycles -> bus outputs stable, StallM=1, bubbles (RegWriteEnW=0) in WB throughout.
- rst asserted mid-ACCESS with ack in the same cycle -> DMemReqO=0 and all WB outputs 0 next cycle; no writeback.
- With MEM_MISALIGN_CHECK_EN, word load at 0x102 -> no DMemReqO, StallM=0, MisalignW=1 for one cycle, RegWriteEnW=0.
